// File: rtl/adder_checker.sv
// adder_checker: receiving-end checker for the WIDTH-bit adder bench.
// Samples {cin,a,b} with the adder's {carry,sum}, counts vectors, result
// mismatches and out-of-order stimulus, and latches the first failing vector.
// Optional feature macro: ADDER_CHK_HALT_EN (end the run on the first mismatch).
module adder_checker #(
  parameter int WIDTH   = 4,
  parameter int NUM_VEC = 512
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               vld,
  input  logic [0:WIDTH-1]   a,
  input  logic [0:WIDTH-1]   b,
  input  logic               cin,
  input  logic [0:WIDTH-1]   sum,
  input  logic               carry,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [15:0]        vec_cnt,
  output logic [15:0]        err_cnt,
  output logic               ord_err,
  output logic [15:0]        first_err_idx,
  output logic [WIDTH:0]     first_err_rsp
);

  localparam int IDX_W = 2 * WIDTH + 1;

`ifdef ADDER_CHK_HALT_EN
  localparam bit HALT_ON_ERR = 1'b1;
`else
  localparam bit HALT_ON_ERR = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic               accept;
  logic               clear;
  logic               mismatch;
  logic               last_vec;
  logic [WIDTH:0]     exp_rsp;
  logic [WIDTH:0]     act_rsp;
  logic [IDX_W-1:0]   stim_idx;
  logic [15:0]        stim_idx_w;
  logic [15:0]        vec_cnt_nxt;

  // Error counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) return v;
    return v + 16'd1;
  endfunction

  // Index 0 of the operand vectors is the MSB, so the declared ranges
  // already carry the natural numeric weighting.
  assign exp_rsp     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign act_rsp     = {carry, sum};
  assign mismatch    = (act_rsp != exp_rsp);
  assign stim_idx    = {cin, a, b};
  assign stim_idx_w  = 16'(stim_idx);
  assign vec_cnt_nxt = vec_cnt + 16'd1;
  assign last_vec    = (vec_cnt_nxt == 16'(NUM_VEC));

  // A start in RUN is ignored; a vector outside RUN is ignored.
  assign accept = (state == RUN) && vld;
  assign clear  = start && (state != RUN);

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = (state == DONE) && (err_cnt == 16'd0) && !ord_err;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: runs end on the final vector or, in halt builds, the first mismatch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (accept && (last_vec || (HALT_ON_ERR && mismatch))) state_nxt = DONE;
      DONE: if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Run statistics: cleared on run entry, updated on each accepted vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_cnt       <= '0;
      err_cnt       <= '0;
      ord_err       <= 1'b0;
      first_err_idx <= '0;
      first_err_rsp <= '0;
    end else if (clear) begin
      vec_cnt       <= '0;
      err_cnt       <= '0;
      ord_err       <= 1'b0;
      first_err_idx <= '0;
      first_err_rsp <= '0;
    end else if (accept) begin
      vec_cnt <= vec_cnt_nxt;
      if (stim_idx_w != vec_cnt) ord_err <= 1'b1;
      if (mismatch) begin
        err_cnt <= sat_inc(err_cnt);
        // err_cnt saturates rather than wrapping, so zero means no mismatch yet.
        if (err_cnt == 16'd0) begin
          first_err_idx <= vec_cnt;
          first_err_rsp <= act_rsp;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_checker.sv
// tb_adder_checker: directed scoreboard bench for adder_checker.
// Stimulus pushes expected status snapshots; a monitor compares them at negedge.
module tb_adder_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, vld, cin, carry;
  logic [0:3]  a, b, sum;
  logic        busy, done, pass, ord_err;
  logic [15:0] vec_cnt, err_cnt, first_err_idx;
  logic [4:0]  first_err_rsp;

  typedef struct {
    string       name;
    logic [56:0] v;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  adder_checker #(.WIDTH(4), .NUM_VEC(512)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vld(vld),
    .a(a), .b(b), .cin(cin), .sum(sum), .carry(carry),
    .busy(busy), .done(done), .pass(pass),
    .vec_cnt(vec_cnt), .err_cnt(err_cnt), .ord_err(ord_err),
    .first_err_idx(first_err_idx), .first_err_rsp(first_err_rsp)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Correct adder response for a stimulus index.
  function automatic logic [4:0] good(input logic [8:0] idx);
    return 5'(idx[7:4]) + 5'(idx[3:0]) + 5'(idx[8]);
  endfunction

  task automatic e(input string name, input logic bz, input logic dn, input logic ps,
                   input logic oe, input int vc, input int ec, input int fi,
                   input logic [4:0] fr);
    exp_t x;
    x.name = name;
    x.v    = {bz, dn, ps, oe, 16'(vc), 16'(ec), 16'(fi), fr};
    q.push_back(x);
  endtask

  task automatic apply(input logic [8:0] idx, input logic [4:0] rsp, input logic v, input logic s);
    {cin, a, b}  = idx;
    {carry, sum} = rsp;
    vld   = v;
    start = s;
    @(posedge clk);
    #1;
    vld   = 1'b0;
    start = 1'b0;
  endtask

  // Monitor: compare every queued expectation against the live outputs.
  always @(negedge clk) begin
    exp_t        x;
    logic [56:0] act;
    while (q.size() > 0) begin
      x   = q.pop_front();
      act = {busy, done, pass, ord_err, vec_cnt, err_cnt, first_err_idx, first_err_rsp};
      n_chk++;
      if (act === x.v) n_pass++;
      else $display("FAIL %s: got %h required %h", x.name, act, x.v);
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; vld = 1'b0;
    cin = 1'b0; a = '0; b = '0; sum = '0; carry = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    e("reset_state", 0, 0, 0, 0, 0, 0, 0, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // vld in IDLE is ignored
    apply(9'd0, good(9'd0), 1'b1, 1'b0);
    e("idle_vld_ignored", 0, 0, 0, 0, 0, 0, 0, 5'd0);

    // clean exhaustive sweep
    apply(9'd0, 5'd0, 1'b0, 1'b1);
    e("start_busy", 1, 0, 0, 0, 0, 0, 0, 5'd0);
    for (int i = 0; i < 512; i++) begin
      apply(9'(i), good(9'(i)), 1'b1, 1'b0);
      if (i == 0)   e("clean_first", 1, 0, 0, 0, 1, 0, 0, 5'd0);
      if (i == 510) e("clean_511", 1, 0, 0, 0, 511, 0, 0, 5'd0);
    end
    e("clean_done", 0, 1, 1, 0, 512, 0, 0, 5'd0);
    apply(9'd0, 5'h1f, 1'b1, 1'b0);
    e("done_vld_ignored", 0, 1, 1, 0, 512, 0, 0, 5'd0);

`ifdef ADDER_CHK_HALT_EN
    // halt on first mismatch
    apply(9'd0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) apply(9'(i), good(9'(i)), 1'b1, 1'b0);
    e("halt_pre", 1, 0, 0, 0, 10, 0, 0, 5'd0);
    apply(9'd10, 5'd0, 1'b1, 1'b0);
    e("halt_done", 0, 1, 0, 0, 11, 1, 10, 5'd0);
    apply(9'd11, good(9'd11), 1'b1, 1'b0);
    apply(9'd12, 5'd3, 1'b1, 1'b0);
    e("halt_ignored", 0, 1, 0, 0, 11, 1, 10, 5'd0);
`else
    // single fault at index 255; start+vld in DONE starts without accepting
    apply(9'd5, good(9'd5), 1'b1, 1'b1);
    e("start_vld_in_done", 1, 0, 0, 0, 0, 0, 0, 5'd0);
    for (int i = 0; i < 512; i++) begin
      apply(9'(i), (i == 255) ? 5'd0 : good(9'(i)), 1'b1, 1'b0);
      if (i == 254) e("fault_pre", 1, 0, 0, 0, 255, 0, 0, 5'd0);
      if (i == 255) e("fault_latched", 1, 0, 0, 0, 256, 1, 255, 5'd0);
    end
    e("fault_done", 0, 1, 0, 0, 512, 1, 255, 5'd0);
`endif

    // out-of-order stimulus; start+vld in RUN accepts the vector
    apply(9'd0, 5'd0, 1'b0, 1'b1);
    apply(9'd0, good(9'd0), 1'b1, 1'b0);
    apply(9'd1, good(9'd1), 1'b1, 1'b1);
    e("start_vld_in_run", 1, 0, 0, 0, 2, 0, 0, 5'd0);
    apply(9'd3, good(9'd3), 1'b1, 1'b0);
    e("ord_err_set", 1, 0, 0, 1, 3, 0, 0, 5'd0);
    for (int i = 3; i < 512; i++) apply(9'(i), good(9'(i)), 1'b1, 1'b0);
    e("ord_done", 0, 1, 0, 1, 512, 0, 0, 5'd0);

    // alternate-cycle vld gaps
    apply(9'd0, 5'd0, 1'b0, 1'b1);
    e("gap_start", 1, 0, 0, 0, 0, 0, 0, 5'd0);
    for (int i = 0; i < 512; i++) begin
      apply(9'(i), good(9'(i)), 1'b1, 1'b0);
      if (i == 511) e("gap_done", 0, 1, 1, 0, 512, 0, 0, 5'd0);
      else begin
        e("gap_vec", 1, 0, 0, 0, i + 1, 0, 0, 5'd0);
        apply(9'h1AA, 5'd0, 1'b0, 1'b0);
        e("gap_idle", 1, 0, 0, 0, i + 1, 0, 0, 5'd0);
      end
    end

    // reset mid-run (with a fault already recorded)
    apply(9'd0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++)
      apply(9'(i), (i == 50) ? 5'd0 : good(9'(i)), 1'b1, 1'b0);
    rst_n = 1'b0;
    e("reset_async", 0, 0, 0, 0, 0, 0, 0, 5'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    e("after_reset_idle", 0, 0, 0, 0, 0, 0, 0, 5'd0);
    apply(9'd0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 512; i++) apply(9'(i), good(9'(i)), 1'b1, 1'b0);
    e("post_reset_done", 0, 1, 1, 0, 512, 0, 0, 5'd0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
